// File: rtl/alu_pkg.sv
// Shared definitions for ALU initiators: widths, opcodes, instruction layout,
// issue-controller state encoding and flag bit positions.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned IMM_W  = 11;

  // ALU opcodes. 01000 is the only legal op with F[4]=0.
  localparam logic [OP_W-1:0] ALU_SHL1     = 5'b01000;
  localparam logic [OP_W-1:0] ALU_ZERO     = 5'b10000;
  localparam logic [OP_W-1:0] ALU_AND      = 5'b10001;
  localparam logic [OP_W-1:0] ALU_OR       = 5'b10010;
  localparam logic [OP_W-1:0] ALU_PASSB    = 5'b10011;
  localparam logic [OP_W-1:0] ALU_PASSA    = 5'b10100;
  localparam logic [OP_W-1:0] ALU_XOR      = 5'b10101;
  localparam logic [OP_W-1:0] ALU_NOTA     = 5'b10110;
  localparam logic [OP_W-1:0] ALU_NOTB     = 5'b10111;
  localparam logic [OP_W-1:0] ALU_ADD      = 5'b11000;
  localparam logic [OP_W-1:0] ALU_SUB      = 5'b11001;
  localparam logic [OP_W-1:0] ALU_INC      = 5'b11010;
  localparam logic [OP_W-1:0] ALU_DEC      = 5'b11011;
  localparam logic [OP_W-1:0] ALU_SHR1     = 5'b11100;
  localparam logic [OP_W-1:0] ALU_ASR1     = 5'b11101;
  localparam logic [OP_W-1:0] ALU_ONES     = 5'b11110;
  localparam logic [OP_W-1:0] ALU_ONES_CLR = 5'b11111;

  // Instruction field positions (LSB of each field).
  localparam int unsigned F_LSB       = 27;
  localparam int unsigned RD_LSB      = 22;
  localparam int unsigned RA_LSB      = 17;
  localparam int unsigned RB_LSB      = 12;
  localparam int unsigned USE_IMM_BIT = 11;
  localparam int unsigned IMM_LSB     = 0;

  // Flag register layout {O,S,C,Z}.
  localparam int unsigned FLAG_O = 3;
  localparam int unsigned FLAG_S = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StExec,
    StWb,
    StErr
  } issue_state_e;

  // Sign-extend the immediate field to the datapath width.
  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Opcode decoder: classifies the F field as legal and maps it to the ALU op.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [OP_W-1:0] f,
  output logic            legal,
  output logic [OP_W-1:0] op
);

  // Legal set is SHL1 plus the whole upper half of the opcode space.
  always_comb begin
    legal = (f == ALU_SHL1) || f[OP_W-1];
    op    = f;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller: accepts an instruction, reads operands,
// drives the ALU, captures result/flags and writes back.
module alu_issue_ctrl
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [REG_AW-1:0] rf_ra_addr,
  output logic [REG_AW-1:0] rf_rb_addr,
  input  logic [DATA_W-1:0] rf_ra_data,
  input  logic [DATA_W-1:0] rf_rb_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_o,
  input  logic              alu_c,
  output logic [3:0]        flags,
  output logic              done,
  output logic              err
);

  issue_state_e state;

  logic [OP_W-1:0]   dec_op;
  logic              dec_legal;

  // Fields held for the lifetime of the in-flight instruction.
  logic [OP_W-1:0]   op_q;
  logic [REG_AW-1:0] rd_q;
  logic              use_imm_q;
  logic [IMM_W-1:0]  imm_q;

  // Flag bits captured from the ALU at the end of EXEC.
  logic              o_cap;
  logic              c_cap;

  alu_op_decode u_dec (
    .f     (instr[F_LSB +: OP_W]),
    .legal (dec_legal),
    .op    (dec_op)
  );

  // Ready is a pure decode of the state register.
  assign instr_ready = (state == StIdle);

  // Issue FSM with registered datapath outputs and single-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      op_q       <= ALU_ZERO;
      rd_q       <= '0;
      use_imm_q  <= 1'b0;
      imm_q      <= '0;
      o_cap      <= 1'b0;
      c_cap      <= 1'b0;
      rf_ra_addr <= '0;
      rf_rb_addr <= '0;
      rf_we      <= 1'b0;
      rf_wa      <= '0;
      rf_wd      <= '0;
      alu_op     <= ALU_ZERO;
      alu_a      <= '0;
      alu_b      <= '0;
      flags      <= 4'b0000;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      // Pulses default low; only one state ever raises one of them.
      rf_we <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      unique case (state)
        StIdle: begin
          if (instr_valid) begin
            op_q       <= dec_op;
            rd_q       <= instr[RD_LSB +: REG_AW];
            use_imm_q  <= instr[USE_IMM_BIT];
            imm_q      <= instr[IMM_LSB +: IMM_W];
            rf_ra_addr <= instr[RA_LSB +: REG_AW];
            rf_rb_addr <= instr[RB_LSB +: REG_AW];
            if (dec_legal) begin
              state <= StRead;
            end else begin
              state <= StErr;
              err   <= 1'b1;
            end
          end
        end
        StRead: begin
          alu_a  <= rf_ra_data;
          alu_b  <= use_imm_q ? sext_imm(imm_q) : rf_rb_data;
          alu_op <= op_q;
          state  <= StExec;
        end
        StExec: begin
          // rf_wd doubles as the result holding register for the flag update.
          rf_wd <= alu_res;
          o_cap <= alu_o;
          c_cap <= alu_c;
          rf_wa <= rd_q;
          rf_we <= (rd_q != '0);
          done  <= 1'b1;
          state <= StWb;
        end
        StWb: begin
          // S and Z come from the captured result, not from the ALU.
          flags[FLAG_O] <= o_cap;
          flags[FLAG_S] <= rf_wd[DATA_W-1];
          flags[FLAG_C] <= c_cap;
          flags[FLAG_Z] <= (rf_wd == '0);
          state         <= StIdle;
        end
        StErr: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a small register file
// and ALU stub.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  rf_ra_addr;
  logic [4:0]  rf_rb_addr;
  logic [31:0] rf_ra_data;
  logic [31:0] rf_rb_data;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [4:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_res;
  logic        alu_o;
  logic        alu_c;
  logic [3:0]  flags;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rf_ra_addr  (rf_ra_addr),
    .rf_rb_addr  (rf_rb_addr),
    .rf_ra_data  (rf_ra_data),
    .rf_rb_data  (rf_rb_data),
    .rf_we       (rf_we),
    .rf_wa       (rf_wa),
    .rf_wd       (rf_wd),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_res     (alu_res),
    .alu_o       (alu_o),
    .alu_c       (alu_c),
    .flags       (flags),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: the controller's registered address is the read stage.
  logic [31:0] regs [32];
  logic        load_en;
  logic [4:0]  load_addr;
  logic [31:0] load_data;

  assign rf_ra_data = regs[rf_ra_addr];
  assign rf_rb_data = regs[rf_rb_addr];

  always @(posedge clk) begin
    if (load_en) regs[load_addr] <= load_data;
    else if (rf_we) regs[rf_wa] <= rf_wd;
  end

  // ALU stub covering the ops this bench issues.
  logic [32:0] sum;
  always_comb begin
    alu_res = '0;
    alu_o   = 1'b0;
    alu_c   = 1'b0;
    sum     = {1'b0, alu_a} + {1'b0, alu_b};
    case (alu_op)
      5'b10001: alu_res = alu_a & alu_b;
      5'b10011: alu_res = alu_b;
      5'b11111: alu_res = '0;
      5'b11000: begin
        alu_res = sum[31:0];
        alu_c   = sum[32];
        alu_o   = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
      end
      default:  alu_res = alu_a ^ alu_b;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] f, input logic [4:0] rd,
                                     input logic [4:0] ra, input logic [4:0] rb,
                                     input logic use_imm, input logic [10:0] imm);
    return {f, rd, ra, rb, use_imm, imm};
  endfunction

  task automatic load_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Issue one legal instruction and check every cycle up to the flag update.
  task automatic run(input string tag, input logic [31:0] ins, input logic [4:0] exp_wa,
                     input logic [31:0] exp_wd, input logic exp_we, input logic [3:0] exp_flags);
    @(negedge clk);
    check({tag, "_ready_idle"}, instr_ready, 1'b1);
    instr_valid = 1'b1;
    instr       = ins;
    @(negedge clk);  // READ
    instr_valid = 1'b0;
    check({tag, "_ready_busy"}, instr_ready, 1'b0);
    check({tag, "_done_read"}, done, 1'b0);
    @(negedge clk);  // EXEC
    check({tag, "_we_exec"}, rf_we, 1'b0);
    check({tag, "_done_exec"}, done, 1'b0);
    @(negedge clk);  // WB
    check({tag, "_we"}, rf_we, exp_we);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_wa"}, rf_wa, exp_wa);
    check({tag, "_wd"}, rf_wd, exp_wd);
    @(negedge clk);  // IDLE
    check({tag, "_flags"}, flags, exp_flags);
    check({tag, "_ready_back"}, instr_ready, 1'b1);
    check({tag, "_done_clr"}, done, 1'b0);
  endtask

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 32'hFFFF_FFFF;
    load_en     = 1'b0;
    load_addr   = '0;
    load_data   = '0;
    for (int i = 0; i < 32; i++) regs[i] = '0;

    #1;
    check("rst_we", rf_we, 1'b0);
    check("rst_err", err, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", instr_ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_flags", flags, 4'b0000);
    check("rst_aluop", alu_op, 5'b10000);
    check("rst_alua", alu_a, 32'h0);
    check("rst_alub", alu_b, 32'h0);
    check("rst_ra", rf_ra_addr, 5'd0);
    check("rst_rb", rf_rb_addr, 5'd0);
    check("rst_wa", rf_wa, 5'd0);
    check("rst_wd", rf_wd, 32'h0);

    load_reg(5'd3, 32'h0000_0F0F);
    load_reg(5'd4, 32'h0000_00FF);

    // AND r5 = r3 & r4, also look at ALU operands during EXEC.
    fork
      run("and", mk(5'b10001, 5'd5, 5'd3, 5'd4, 1'b0, 11'h0), 5'd5, 32'h0000_000F, 1'b1,
          4'b0000);
      begin
        repeat (3) @(negedge clk);
        check("and_op", alu_op, 5'b10001);
        check("and_a", alu_a, 32'h0000_0F0F);
        check("and_b", alu_b, 32'h0000_00FF);
      end
    join

    run("onesclr", mk(5'b11111, 5'd6, 5'd3, 5'd4, 1'b0, 11'h0), 5'd6, 32'h0, 1'b1, 4'b0001);
    run("passb_imm", mk(5'b10011, 5'd7, 5'd3, 5'd4, 1'b1, 11'h7FF), 5'd7, 32'hFFFF_FFFF, 1'b1,
        4'b0100);
    check("wb_r5", regs[5], 32'h0000_000F);

    // Illegal op: err pulse only, flags untouched.
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = mk(5'b00001, 5'd9, 5'd3, 5'd4, 1'b0, 11'h0);
    @(negedge clk);
    instr_valid = 1'b0;
    check("ill_err", err, 1'b1);
    check("ill_ready_busy", instr_ready, 1'b0);
    check("ill_we", rf_we, 1'b0);
    check("ill_done", done, 1'b0);
    @(negedge clk);
    check("ill_err_clr", err, 1'b0);
    check("ill_ready_back", instr_ready, 1'b1);
    check("ill_we2", rf_we, 1'b0);
    check("ill_flags", flags, 4'b0100);
    check("ill_r9", regs[9], 32'h0);

    // Carry out with zero result.
    load_reg(5'd1, 32'hFFFF_FFFF);
    load_reg(5'd2, 32'h0000_0001);
    run("add_c", mk(5'b11000, 5'd8, 5'd1, 5'd2, 1'b0, 11'h0), 5'd8, 32'h0, 1'b1, 4'b0011);

    // Valid held across two instructions; first targets r0.
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = mk(5'b10001, 5'd0, 5'd5, 5'd3, 1'b0, 11'h0);
    @(negedge clk);  // READ of first
    instr = mk(5'b10011, 5'd9, 5'd0, 5'd0, 1'b1, 11'h400);
    check("hold_ready1", instr_ready, 1'b0);
    @(negedge clk);  // EXEC
    check("hold_ready2", instr_ready, 1'b0);
    @(negedge clk);  // WB of first
    check("r0_done", done, 1'b1);
    check("r0_we", rf_we, 1'b0);
    check("hold_ready3", instr_ready, 1'b0);
    @(negedge clk);  // IDLE: second accepted at the coming edge
    check("hold_ready4", instr_ready, 1'b1);
    check("r0_flags", flags, 4'b0000);
    @(negedge clk);
    instr_valid = 1'b0;
    check("hold2_busy", instr_ready, 1'b0);
    @(negedge clk);
    check("hold2_b", alu_b, 32'hFFFF_FC00);
    @(negedge clk);
    check("hold2_we", rf_we, 1'b1);
    check("hold2_wa", rf_wa, 5'd9);
    check("hold2_wd", rf_wd, 32'hFFFF_FC00);
    @(negedge clk);
    check("hold2_flags", flags, 4'b0100);
    check("r0_stays", regs[0], 32'h0);

    // Signed overflow through the immediate path.
    load_reg(5'd10, 32'h7FFF_FFFF);
    run("add_o", mk(5'b11000, 5'd11, 5'd10, 5'd0, 1'b1, 11'h001), 5'd11, 32'h8000_0000, 1'b1,
        4'b1100);

    // Reset during EXEC drops the instruction.
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = mk(5'b10001, 5'd12, 5'd3, 5'd4, 1'b0, 11'h0);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);  // EXEC
    rst = 1'b1;
    #1;
    check("mrst_ready", instr_ready, 1'b1);
    check("mrst_we", rf_we, 1'b0);
    check("mrst_done", done, 1'b0);
    check("mrst_flags", flags, 4'b0000);
    check("mrst_aluop", alu_op, 5'b10000);
    check("mrst_alua", alu_a, 32'h0);
    check("mrst_wd", rf_wd, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("mrst_no_we", rf_we, 1'b0);
      check("mrst_no_done", done, 1'b0);
    end
    check("mrst_r12", regs[12], 32'h0);
    run("post_rst", mk(5'b10011, 5'd13, 5'd0, 5'd0, 1'b1, 11'h000), 5'd13, 32'h0, 1'b1,
        4'b0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got stalled expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Multi-cycle issue controller that drives the combinational ALU (5-bit OP, 32-bit A/B, RES, O/S/C/Z) from an instruction stream. Accepts one instruction per valid/ready handshake and decodes the ALU op and operand sources. Reads the register file (1-cycle synchronous read), presents operands to the ALU, then captures RES and flags. Writes back the result and updates a flag register; sits between fetch and the ALU/register file in the datapath.

Parameters:
DATA_W, 32, datapath width (A, B, RES, register data)
OP_W, 5, ALU opcode width
REG_AW, 5, register-file address width
IMM_W, 11, immediate field width, sign-extended to DATA_W

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
instr_valid  input  1  instruction present
instr_ready  output  1  controller can accept (IDLE only)
instr  input  32  [31:27] F op, [26:22] rd, [21:17] ra, [16:12] rb, [11] use_imm, [10:0] imm
rf_ra_addr  output  REG_AW  register-file read port A address
rf_rb_addr  output  REG_AW  register-file read port B address
rf_ra_data  input  DATA_W  port A data, valid 1 cycle after address
rf_rb_data  input  DATA_W  port B data, valid 1 cycle after address
rf_we  output  1  write-enable pulse
rf_wa  output  REG_AW  write address
rf_wd  output  DATA_W  write data
alu_op  output  OP_W  ALU opcode
alu_a  output  DATA_W  ALU operand A
alu_b  output  DATA_W  ALU operand B
alu_res  input  DATA_W  ALU result (combinational)
alu_o  input  1  ALU overflow
alu_c  input  1  ALU carry
flags  output  4  registered {O,S,C,Z}
done  output  1  1-cycle pulse per retired legal instruction
err  output  1  1-cycle pulse per rejected (illegal-op) instruction

Behaviour:
- Reset (async, rst=1): state=IDLE; instr_ready=1 once rst deasserts; rf_we=0, done=0, err=0; flags=4'b0000; alu_op=5'b10000 (zero op); alu_a=alu_b=rf_ra_addr=rf_rb_addr=rf_wa=rf_wd=0.
- Legal F: 5'b01000 and 5'b10000..5'b11111. All other F are illegal. alu_op=F (identity mapping).
- States: IDLE -> READ -> EXEC -> WB -> IDLE; IDLE -> ERR -> IDLE for illegal F.
- IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr fields and drive rf_ra_addr/rf_rb_addr next cycle. Legal F -> READ; illegal F -> ERR.
- READ: wait for register data. Registers alu_a=rf_ra_data. Registers alu_b=use_imm ? sext(imm) : rf_rb_data. Registers alu_op=F. -> EXEC.
- EXEC: ALU inputs stable. Capture alu_res, alu_o, alu_c into holding registers at end of cycle. -> WB.
- WB: rf_wa=rd, rf_wd=captured res, rf_we=1 unless rd==0 (r0 writes suppressed). flags <= {O_cap, res[31], C_cap, res==0} (S and Z computed locally, not taken from ALU). done=1. -> IDLE.
- ERR: err=1 for one cycle; no rf_we; flags unchanged. -> IDLE.
- Latency: accept at edge N -> rf_we/done asserted in cycle N+3. Max throughput 1 instruction per 4 cycles; instr_ready=0 in READ/EXEC/WB/ERR.
- instr_valid held through busy cycles: nothing sampled; the instruction is accepted on the next IDLE cycle.
- instr changing while instr_ready=0 is ignored.
- Reset mid-operation: in-flight instruction dropped; no rf_we/done/err; flags cleared.
- rf_we, done and err are mutually exclusive and single-cycle.
- Immediate: sext copies imm[10] into bits [31:11].

Decomposition:
- Shared package alu_pkg: OP_W/DATA_W constants, named localparams for all ALU opcodes (e.g. ALU_SHL1=5'b01000, ALU_ZERO=5'b10000, ALU_AND=5'b10001, ALU_PASSB=5'b10011, ALU_ONES_CLR=5'b11111), instruction field offsets, state encoding, flag bit indices.
- One sub-module: alu_op_decode (combinational: F -> legal bit, alu_op). Shared later with other ALU initiators.

Test Plan:
- Reset, then r3=0x00000F0F, r4=0x000000FF; issue F=10001 rd=5 ra=3 rb=4 -> rf_we at accept+3, rf_wa=5, rf_wd=0x0000000F, flags Z=0 S=0, done pulse.
- F=11111 rd=6 -> rf_wd=0x00000000, flags Z=1.
- F=10011 use_imm=1 imm=11'h7FF rd=7 -> rf_wd=0xFFFFFFFF, flags S=1 Z=0.
- F=00001 (illegal) -> err pulse at accept+1; no rf_we; flags unchanged; instr_ready back at accept+2.
- instr_valid held high with two instructions -> second accepted exactly 4 cycles after the first; rd=0 instruction retires with done=1 but rf_we=0.
- rst asserted during EXEC -> outputs at reset values immediately; no rf_we; flags=0; next instruction completes normally.
